mips_lsu: RTL and testbench

Load/store unit directly downstream of the MIPS core's execute stage. It accepts one load or store request per transaction and forms byte-lane write enables and replicated store data. It drives a variable-latency data memory through a req/ack handshake and returns aligned, sign- or zero-extended load data. It also detects misaligned accesses, memory errors and memory timeouts, and reports each as an exception to the core's exception unit.

---
 rtl/mips_lsu_pkg.sv | 68 ++++++
 rtl/mips_lsu_align.sv | 32 +++
 rtl/mips_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_mips_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mips_lsu_pkg
// Shared definitions for the MIPS load/store unit: access-size encodings, the
// LSU FSM state type, and the lane/extraction helpers used by the datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 (reserved) behaves as a word

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   // Little-endian byte-lane write mask for an access of the given size.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << lo;
         SZ_HALF: m = 4'b0011 << lo;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Right-justified store data replicated so every candidate lane carries it.
   function automatic logic [31:0] store_repl(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // Pick the addressed byte/half out of the read word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Natural alignment check; bytes are always aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic m;
      case (size)
         SZ_BYTE: m = 1'b0;
         SZ_HALF: m = lo[0];
         default: m = (lo != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   i_size, i_addr_lo, i_signed : access descriptor
//   i_wdata                     : right-justified store data
//   i_rdata                     : raw word read from memory
//   o_mask                      : byte-lane write mask
//   o_wdata                     : store data replicated across lanes
//   o_rdata                     : extracted, extended load data
//   o_misalign                  : access is not naturally aligned
// -----------------------------------------------------------------------------
module lsu_align
   import mips_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_mask,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   assign o_mask     = lane_mask(i_size, i_addr_lo);
   assign o_wdata    = store_repl(i_size, i_wdata);
   assign o_rdata    = load_extract(i_size, i_signed, i_addr_lo, i_rdata);
   assign o_misalign = misaligned(i_size, i_addr_lo);

endmodule

// File: rtl/mips_lsu.sv
// -----------------------------------------------------------------------------
// mips_lsu
// Load/store unit between the MIPS execute stage and a variable-latency data
// memory. One transaction at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP
// directly for a misaligned request. All outputs are registered.
// Ports:
//   i_clk, i_rst_b       : clock, synchronous active-high reset
//   i_req_*, o_req_ready : request from the core (accepted only in IDLE)
//   o_resp_valid/rdata   : one-cycle completion pulse with extended load data
//   o_excpt_adel/ades/dbe, o_bad_addr : exception report, valid with resp
//   o_mem_*, i_mem_*     : word-addressed memory req/ack interface
// -----------------------------------------------------------------------------
module mips_lsu
   import mips_lsu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8
)(
   input  logic        i_clk,
   input  logic        i_rst_b,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_signed,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_excpt_adel,
   output logic        o_excpt_ades,
   output logic        o_excpt_dbe,
   output logic [31:0] o_bad_addr,
   output logic        o_mem_req,
   output logic [29:0] o_mem_addr,
   output logic [31:0] o_mem_data_in,
   output logic [3:0]  o_mem_write_en,
   input  logic [31:0] i_mem_data_out,
   input  logic        i_mem_ack,
   input  logic        i_mem_excpt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   lsu_state_e        r_state, w_state_nxt;
   logic [31:0]       r_addr, w_addr_nxt;
   logic [1:0]        r_size, w_size_nxt;
   logic              r_signed, w_signed_nxt;
   logic              r_is_store, w_is_store_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic              r_req_ready, w_req_ready_nxt;
   logic              r_resp_valid, w_resp_valid_nxt;
   logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
   logic              r_adel, w_adel_nxt;
   logic              r_ades, w_ades_nxt;
   logic              r_dbe, w_dbe_nxt;
   logic [31:0]       r_bad_addr, w_bad_addr_nxt;
   logic              r_mem_req, w_mem_req_nxt;
   logic [29:0]       r_mem_addr, w_mem_addr_nxt;
   logic [31:0]       r_mem_din, w_mem_din_nxt;
   logic [3:0]        r_mem_we, w_mem_we_nxt;

   // Lane logic sees the live request while IDLE and the latched one afterwards.
   logic [1:0]        w_size;
   logic [1:0]        w_lo;
   logic              w_signed;
   logic [3:0]        w_mask;
   logic [31:0]       w_st_data;
   logic [31:0]       w_ld_data;
   logic              w_misalign;

   assign w_size   = (r_state == ST_IDLE) ? i_req_size      : r_size;
   assign w_lo     = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_addr[1:0];
   assign w_signed = (r_state == ST_IDLE) ? i_req_signed    : r_signed;

   lsu_align u_align (
      .i_size     (w_size),
      .i_addr_lo  (w_lo),
      .i_signed   (w_signed),
      .i_wdata    (i_req_wdata),
      .i_rdata    (i_mem_data_out),
      .o_mask     (w_mask),
      .o_wdata    (w_st_data),
      .o_rdata    (w_ld_data),
      .o_misalign (w_misalign)
   );

   // Next-state and next-output logic for the LSU FSM.
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_size_nxt       = r_size;
      w_signed_nxt     = r_signed;
      w_is_store_nxt   = r_is_store;
      w_cnt_nxt        = r_cnt;
      w_req_ready_nxt  = r_req_ready;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = r_resp_rdata;
      w_adel_nxt       = r_adel;
      w_ades_nxt       = r_ades;
      w_dbe_nxt        = r_dbe;
      w_bad_addr_nxt   = r_bad_addr;
      w_mem_req_nxt    = r_mem_req;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_din_nxt    = r_mem_din;
      w_mem_we_nxt     = r_mem_we;

      case (r_state)
         ST_IDLE: begin
            if (i_req_valid) begin
               w_req_ready_nxt = 1'b0;
               w_addr_nxt      = i_req_addr;
               w_size_nxt      = i_req_size;
               w_signed_nxt    = i_req_signed;
               w_is_store_nxt  = i_req_we;
               if (w_misalign) begin
                  // Report immediately; memory is never touched.
                  w_state_nxt      = ST_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_rdata_nxt = 32'h0000_0000;
                  w_adel_nxt       = ~i_req_we;
                  w_ades_nxt       = i_req_we;
                  w_dbe_nxt        = 1'b0;
                  w_bad_addr_nxt   = i_req_addr;
               end else begin
                  w_state_nxt    = ST_ACCESS;
                  w_mem_req_nxt  = 1'b1;
                  w_mem_addr_nxt = i_req_addr[31:2];
                  w_mem_din_nxt  = w_st_data;
                  w_mem_we_nxt   = i_req_we ? w_mask : 4'b0000;
                  w_cnt_nxt      = {CNT_W{1'b0}};
               end
            end else begin
               w_req_ready_nxt = 1'b1;
            end
         end

         ST_ACCESS: begin
            if (i_mem_ack) begin
               w_state_nxt      = ST_RESP;
               w_resp_valid_nxt = 1'b1;
               w_mem_req_nxt    = 1'b0;
               w_mem_we_nxt     = 4'b0000;
               w_dbe_nxt        = i_mem_excpt;
               if (i_mem_excpt) begin
                  w_resp_rdata_nxt = 32'h0000_0000;
                  w_bad_addr_nxt   = r_addr;
               end else begin
                  w_resp_rdata_nxt = r_is_store ? 32'h0000_0000 : w_ld_data;
               end
            end else if (r_cnt == CNT_LAST) begin
               // Memory never answered: give up and report a bus error.
               w_state_nxt      = ST_RESP;
               w_resp_valid_nxt = 1'b1;
               w_mem_req_nxt    = 1'b0;
               w_mem_we_nxt     = 4'b0000;
               w_dbe_nxt        = 1'b1;
               w_resp_rdata_nxt = 32'h0000_0000;
               w_bad_addr_nxt   = r_addr;
            end else begin
               w_cnt_nxt = (r_cnt != CNT_MAX) ? r_cnt + {{(CNT_W-1){1'b0}}, 1'b1} : r_cnt;
            end
         end

         ST_RESP: begin
            w_state_nxt      = ST_IDLE;
            w_req_ready_nxt  = 1'b1;
            w_resp_rdata_nxt = 32'h0000_0000;
            w_adel_nxt       = 1'b0;
            w_ades_nxt       = 1'b0;
            w_dbe_nxt        = 1'b0;
         end

         default: begin
            w_state_nxt      = ST_IDLE;
            w_req_ready_nxt  = 1'b1;
            w_resp_rdata_nxt = 32'h0000_0000;
            w_adel_nxt       = 1'b0;
            w_ades_nxt       = 1'b0;
            w_dbe_nxt        = 1'b0;
            w_mem_req_nxt    = 1'b0;
            w_mem_we_nxt     = 4'b0000;
         end
      endcase
   end

   // State, latched request and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst_b) begin
         r_state      <= ST_IDLE;
         r_addr       <= 32'h0000_0000;
         r_size       <= 2'b00;
         r_signed     <= 1'b0;
         r_is_store   <= 1'b0;
         r_cnt        <= {CNT_W{1'b0}};
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
         r_adel       <= 1'b0;
         r_ades       <= 1'b0;
         r_dbe        <= 1'b0;
         r_bad_addr   <= 32'h0000_0000;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= 30'h0000_0000;
         r_mem_din    <= 32'h0000_0000;
         r_mem_we     <= 4'b0000;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_size       <= w_size_nxt;
         r_signed     <= w_signed_nxt;
         r_is_store   <= w_is_store_nxt;
         r_cnt        <= w_cnt_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_adel       <= w_adel_nxt;
         r_ades       <= w_ades_nxt;
         r_dbe        <= w_dbe_nxt;
         r_bad_addr   <= w_bad_addr_nxt;
         r_mem_req    <= w_mem_req_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_din    <= w_mem_din_nxt;
         r_mem_we     <= w_mem_we_nxt;
      end
   end

   assign o_req_ready    = r_req_ready;
   assign o_resp_valid   = r_resp_valid;
   assign o_resp_rdata   = r_resp_rdata;
   assign o_excpt_adel   = r_adel;
   assign o_excpt_ades   = r_ades;
   assign o_excpt_dbe    = r_dbe;
   assign o_bad_addr     = r_bad_addr;
   assign o_mem_req      = r_mem_req;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_data_in  = r_mem_din;
   assign o_mem_write_en = r_mem_we;

endmodule

// File: tb/tb_mips_lsu.sv
// -----------------------------------------------------------------------------
// tb_mips_lsu
// Directed bench for mips_lsu. Each request pushes its hand-computed response
// into a scoreboard queue; a negedge monitor pops and compares on resp_valid.
// Memory-side signals are checked inline by the stimulus tasks.
// -----------------------------------------------------------------------------
module tb_mips_lsu;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid;
   logic [31:0] resp_rdata, bad_addr;
   logic        excpt_adel, excpt_ades, excpt_dbe;
   logic        mem_req;
   logic [29:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_data_out;
   logic        mem_ack, mem_excpt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int accept_cyc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        adel;
      logic        ades;
      logic        dbe;
      logic [31:0] bad;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   mips_lsu #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .i_clk          (clk),
      .i_rst_b        (rst_b),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_signed   (req_signed),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_resp_valid   (resp_valid),
      .o_resp_rdata   (resp_rdata),
      .o_excpt_adel   (excpt_adel),
      .o_excpt_ades   (excpt_ades),
      .o_excpt_dbe    (excpt_dbe),
      .o_bad_addr     (bad_addr),
      .o_mem_req      (mem_req),
      .o_mem_addr     (mem_addr),
      .o_mem_data_in  (mem_data_in),
      .o_mem_write_en (mem_write_en),
      .i_mem_data_out (mem_data_out),
      .i_mem_ack      (mem_ack),
      .i_mem_excpt    (mem_excpt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_resp(input logic [31:0] rd, input logic adel, input logic ades,
                              input logic dbe, input logic [31:0] bad, input int lat);
      exp_t e;
      e.rdata = rd; e.adel = adel; e.ades = ades; e.dbe = dbe; e.bad = bad; e.lat = lat;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every resp_valid sample must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst_b && resp_valid) begin
         if (sb_q.size() == 0) begin
            chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, mon_e.rdata);
            chk("resp_adel", {31'd0, excpt_adel}, {31'd0, mon_e.adel});
            chk("resp_ades", {31'd0, excpt_ades}, {31'd0, mon_e.ades});
            chk("resp_dbe",  {31'd0, excpt_dbe},  {31'd0, mon_e.dbe});
            if (mon_e.adel || mon_e.ades || mon_e.dbe)
               chk("resp_bad_addr", bad_addr, mon_e.bad);
            if (mon_e.lat >= 0)
               chk("resp_latency", 32'(cyc + 1 - accept_cyc), 32'(mon_e.lat));
         end
      end
   end

   // Present one request, wait (bounded) for req_ready, return just after the accept edge.
   task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
      int t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      req_valid = 1'b0;
   endtask

   // Memory model: hold off for 'waits' cycles, checking the request is stable, then ack.
   task automatic mem_serve(input int waits, input logic [31:0] data, input logic ex,
                            input logic [29:0] e_addr, input logic [3:0] e_we,
                            input logic [31:0] e_din, input logic chk_din);
      for (int k = 0; k <= waits; k++) begin
         @(negedge clk);
         chk("mem_req_held", {31'd0, mem_req}, 32'd1);
         chk("mem_addr", {2'b00, mem_addr}, {2'b00, e_addr});
         chk("mem_write_en", {28'd0, mem_write_en}, {28'd0, e_we});
         if (chk_din) chk("mem_data_in", mem_data_in, e_din);
         if (k == waits) begin
            mem_ack = 1'b1; mem_data_out = data; mem_excpt = ex;
         end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0; mem_excpt = 1'b0; mem_data_out = 32'h0000_0000;
      @(negedge clk);
      chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
      chk("mem_we_drop", {28'd0, mem_write_en}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst_b = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_data_out = 32'd0; mem_ack = 1'b0; mem_excpt = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_b = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {28'd0, mem_write_en}, 32'd0);
      chk("rst_flags", {29'd0, excpt_adel, excpt_ades, excpt_dbe}, 32'd0);

      // 1: signed byte load at 0x1003, zero-wait
      expect_resp(32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0);
      mem_serve(0, 32'h80FF_FF7F, 1'b0, 30'h0000_0400, 4'b0000, 32'd0, 1'b0);

      // Unsigned byte at 0x1002 of the same word
      expect_resp(32'h0000_00FF, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'd0);
      mem_serve(0, 32'h80FF_FF7F, 1'b0, 30'h0000_0400, 4'b0000, 32'd0, 1'b0);

      // 2: store half at 0x2002, two wait cycles
      expect_resp(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 4);
      send_req(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
      mem_serve(2, 32'h1111_1111, 1'b0, 30'h0000_0800, 4'b1100, 32'hBEEF_BEEF, 1'b1);

      // Store word at 0xA000
      expect_resp(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b1, 2'd2, 1'b0, 32'h0000_A000, 32'h1234_5678);
      mem_serve(0, 32'd0, 1'b0, 30'h0000_2800, 4'b1111, 32'h1234_5678, 1'b1);

      // Signed half at 0x9002 of 0x8001_0000
      expect_resp(32'hFFFF_8001, 1'b0, 1'b0, 1'b0, 32'd0, 3);
      send_req(1'b0, 2'd1, 1'b1, 32'h0000_9002, 32'd0);
      mem_serve(1, 32'h8001_0000, 1'b0, 30'h0000_2400, 4'b0000, 32'd0, 1'b0);

      // Reserved size behaves as a word load
      expect_resp(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b0, 2'd3, 1'b1, 32'h0000_B000, 32'd0);
      mem_serve(0, 32'hCAFE_F00D, 1'b0, 30'h0000_2C00, 4'b0000, 32'd0, 1'b0);

      // 3: misaligned word load at 0x3001
      expect_resp(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_3001, 1);
      send_req(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0);
      @(negedge clk);
      chk("adel_no_mem_req", {31'd0, mem_req}, 32'd0);
      chk("adel_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("adel_ready_back", {31'd0, req_ready}, 32'd1);
      chk("adel_no_mem_req2", {31'd0, mem_req}, 32'd0);

      // Misaligned half store at 0x2003
      expect_resp(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_2003, 1);
      send_req(1'b1, 2'd1, 1'b0, 32'h0000_2003, 32'h0000_ABCD);
      @(negedge clk);
      chk("ades_no_mem_req", {31'd0, mem_req}, 32'd0);
      chk("ades_no_we", {28'd0, mem_write_en}, 32'd0);

      // 4: word load at 0x4000 with no ack -> timeout
      expect_resp(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_4000, TO + 1);
      send_req(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0);
      n = 0;
      @(negedge clk);
      while (mem_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_req_cycles", 32'(n), 32'(TO));
      // Late ack must be ignored
      mem_ack = 1'b1; mem_data_out = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      chk("late_ack_no_req", {31'd0, mem_req}, 32'd0);
      chk("late_ack_ready", {31'd0, req_ready}, 32'd1);
      mem_ack = 1'b0; mem_data_out = 32'd0;

      // 5: memory error on a word load, then unsigned half at 0x5002
      expect_resp(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_6000, 3);
      send_req(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0);
      mem_serve(1, 32'hDEAD_BEEF, 1'b1, 30'h0000_1800, 4'b0000, 32'd0, 1'b0);

      expect_resp(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b0, 2'd1, 1'b0, 32'h0000_5002, 32'd0);
      mem_serve(0, 32'hFFFF_1234, 1'b0, 30'h0000_1400, 4'b0000, 32'd0, 1'b0);

      // 6: reset during a byte store's ACCESS
      send_req(1'b1, 2'd0, 1'b0, 32'h0000_7001, 32'h0000_00A5);
      @(negedge clk);
      chk("st_byte_mem_req", {31'd0, mem_req}, 32'd1);
      chk("st_byte_we", {28'd0, mem_write_en}, 32'h0000_0002);
      chk("st_byte_din", mem_data_in, 32'hA5A5_A5A5);
      rst_b = 1'b1;
      @(posedge clk);
      #1 rst_b = 1'b0;
      @(negedge clk);
      chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst_mem_we", {28'd0, mem_write_en}, 32'd0);
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_resp", {31'd0, resp_valid}, 32'd0);

      expect_resp(32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 32'd0, 2);
      send_req(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
      mem_serve(0, 32'h1357_9BDF, 1'b0, 30'h0000_2000, 4'b0000, 32'd0, 1'b0);

      // Drain the scoreboard
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
